// File: rtl/cv32e40p_ft_pkg.sv
// Shared types for the fault-tolerance error monitor.
// Event-type encodings and the event-log entry layout.
package cv32e40p_ft_pkg;

    localparam int FT_SRC_W = 5;

    localparam logic FT_EVT_CORR = 1'b0;
    localparam logic FT_EVT_DET  = 1'b1;

    typedef struct packed {
        logic [FT_SRC_W-1:0] src;
        logic                typ;
    } ft_evt_t;

endpackage

// File: rtl/cv32e40p_ft_err_fifo.sv
// Synchronous event-log FIFO for the error monitor.
// Full push with a same-cycle pop is accepted.
module cv32e40p_ft_err_fifo
    import cv32e40p_ft_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    clr_i,
    input  logic    push_i,
    input  ft_evt_t data_i,
    input  logic    pop_i,
    output ft_evt_t data_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int AW = $clog2(DEPTH);

    ft_evt_t       mem_q [DEPTH];
    logic [AW:0]   wr_q, wr_d;
    logic [AW:0]   rd_q, rd_d;
    logic          do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    assign wr_d = do_push ? wr_q + 1'b1 : wr_q;
    assign rd_d = do_pop  ? rd_q + 1'b1 : rd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (clr_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push && !clr_i) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/cv32e40p_ft_err_monitor.sv
// Per-source TMR error counters, sticky flags and event log.
// Log and drop counter exist only with CV32E40P_FT_ERR_LOG_EN defined.
module cv32e40p_ft_err_monitor
    import cv32e40p_ft_pkg::*;
#(
    parameter int NUM_SRC    = 8,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int SW        = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] err_corrected_i,
    input  logic [NUM_SRC-1:0] err_detected_i,
    input  logic               clear_i,
    input  logic [SW-1:0]      cnt_sel_i,
    output logic [CNT_W-1:0]   cnt_o,
    output logic [NUM_SRC-1:0] det_flags_o,
    output logic               fatal_o,
    output logic               evt_valid_o,
    input  logic               evt_ready_i,
    output logic [SW-1:0]      evt_src_o,
    output logic               evt_type_o,
    output logic [CNT_W-1:0]   drop_cnt_o
);

    localparam logic [SW:0] NSRC = NUM_SRC[SW:0];

    logic [CNT_W-1:0]   cnt_q [NUM_SRC];
    logic [NUM_SRC-1:0] det_q, det_d;
    logic [NUM_SRC-1:0] corr_eff;
    logic               fatal_q;

    // A detected error on a source supersedes its corrected pulse.
    assign corr_eff = err_corrected_i & ~err_detected_i;
    assign det_d    = det_q | err_detected_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
            det_q   <= '0;
            fatal_q <= 1'b0;
        end else if (clear_i) begin
            for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
            det_q   <= '0;
            fatal_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (corr_eff[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
            det_q   <= det_d;
            fatal_q <= |det_d;
        end
    end

    assign cnt_o       = ({1'b0, cnt_sel_i} < NSRC) ? cnt_q[cnt_sel_i] : '0;
    assign det_flags_o = det_q;
    assign fatal_o     = fatal_q;

`ifdef CV32E40P_FT_ERR_LOG_EN

    localparam int PW = $clog2(NUM_SRC + 1);
    localparam int DW = CNT_W + PW;
    localparam logic [DW-1:0] DMAX = {{PW{1'b0}}, {CNT_W{1'b1}}};

    logic [NUM_SRC-1:0] ev_any;
    logic [PW-1:0]      n_ev, n_drop;
    logic [DW-1:0]      drop_sum;
    logic [CNT_W-1:0]   drop_q, drop_d;
    ft_evt_t            sel_evt, head;
    logic               sel_vld, log_ok, pop, full, empty;
    logic [FT_SRC_W-1:0] unused_src_hi;

    assign ev_any = err_corrected_i | err_detected_i;

    always_comb begin
        sel_vld = 1'b0;
        sel_evt = '0;
        n_ev    = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (ev_any[i]) begin
                sel_vld     = 1'b1;
                sel_evt.src = FT_SRC_W'(i);
                sel_evt.typ = err_detected_i[i] ? FT_EVT_DET : FT_EVT_CORR;
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            n_ev = n_ev + PW'(ev_any[i]);
        end
    end

    assign pop      = evt_valid_o && evt_ready_i;
    assign log_ok   = sel_vld && (!full || pop);
    assign n_drop   = n_ev - PW'(log_ok);
    assign drop_sum = DW'(drop_q) + DW'(n_drop);
    assign drop_d   = (drop_sum > DMAX) ? '1 : drop_sum[CNT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else if (clear_i) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    cv32e40p_ft_err_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clear_i),
        .push_i  (log_ok && !clear_i),
        .data_i  (sel_evt),
        .pop_i   (pop && !clear_i),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign unused_src_hi = head.src;
    assign evt_valid_o   = !empty;
    assign evt_src_o     = head.src[SW-1:0];
    assign evt_type_o    = head.typ;
    assign drop_cnt_o    = drop_q;

`else

    localparam int unused_depth = FIFO_DEPTH;
    logic unused_ready;

    assign unused_ready = evt_ready_i;
    assign evt_valid_o  = 1'b0;
    assign evt_src_o    = '0;
    assign evt_type_o   = 1'b0;
    assign drop_cnt_o   = '0;

`endif

endmodule

// File: doc/cv32e40p_ft_err_monitor.md
CV32E40P_FT_ERR_MONITOR -- requirements
Module: cv32e40p_ft_err_monitor

Interface
REQ-001 Parameter NUM_SRC, default 8, number of TMR-protected blocks reporting errors (2..32).
REQ-002 Parameter CNT_W, default 8, width of each per-source corrected-error counter.
REQ-003 Parameter FIFO_DEPTH, default 4, event-log entries (power of two, >=2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 err_corrected_i  input  NUM_SRC  per-source pulse: voter masked a single-replica mismatch.
REQ-007 err_detected_i  input  NUM_SRC  per-source pulse: voter saw an uncorrectable mismatch.
REQ-008 clear_i  input  1  synchronous clear of counters, sticky flags, log and drop count.
REQ-009 cnt_sel_i  input  $clog2(NUM_SRC)  selects the counter presented on cnt_o.
REQ-010 cnt_o  output  CNT_W  corrected-error count of source cnt_sel_i, combinational mux of registers.
REQ-011 det_flags_o  output  NUM_SRC  sticky per-source uncorrectable flags.
REQ-012 fatal_o  output  1  OR of det_flags_o, registered.
REQ-013 evt_valid_o / evt_ready_i  output / input  1 / 1  event-log read handshake.
REQ-014 evt_src_o  output  $clog2(NUM_SRC)  source index of the head log entry.
REQ-015 evt_type_o  output  1  head entry type: 0 = corrected, 1 = detected.
REQ-016 drop_cnt_o  output  CNT_W  saturating count of events not logged.

Function
REQ-017 An event on source s at edge N SHALL be reflected in cnt_o, det_flags_o, fatal_o and the log at edge N (visible in cycle N+1).
REQ-018 Each corrected counter SHALL increment by 1 per cycle its input is high and saturate at 2^CNT_W-1 without wrapping.
REQ-019 det_flags_o[s] SHALL set when err_detected_i[s] is high and stay set until clear_i or reset.
REQ-020 If both inputs of source s are high in one cycle, the event SHALL count as detected only; the counter SHALL NOT increment.
REQ-021 Per cycle, at most one event SHALL be logged: the lowest-index source with any event, detected taking precedence over corrected for that source.
REQ-022 Every other event that cycle, and any event arriving while the log is full without a same-cycle pop, SHALL increment drop_cnt_o (by the number dropped, saturating).
REQ-023 A log entry SHALL be popped on edges where evt_valid_o and evt_ready_i are both high; evt_src_o/evt_type_o SHALL stay stable while evt_valid_o is high and evt_ready_i is low.
REQ-024 Simultaneous push and pop on a full log SHALL succeed with no drop; on an empty log the pushed entry SHALL appear the next cycle.
REQ-025 clear_i SHALL take priority over same-cycle events and pops: all state returns to reset values; those events are neither counted nor logged.

Reset
REQ-026 On rst all counters, det_flags_o, fatal_o, drop_cnt_o SHALL be 0, the log SHALL be empty and evt_valid_o SHALL be 0, independent of clk.
REQ-027 Reset asserted mid-handshake SHALL discard all entries; no pop is reported after release.

Configuration
REQ-028 Macro CV32E40P_FT_ERR_LOG_EN: defined SHALL compile in the event log and drop counter as specified above.
REQ-029 Undefined: no log storage; evt_valid_o, evt_src_o, evt_type_o, drop_cnt_o SHALL be tied 0; evt_ready_i ignored; counters and flags unchanged.

Structure
REQ-030 Package cv32e40p_ft_pkg SHALL hold the event-type constants (FT_EVT_CORR, FT_EVT_DET) and the log-entry struct typedef.
REQ-031 The log SHALL be a sub-module cv32e40p_ft_err_fifo (synchronous FIFO, full/empty, push/pop) instantiated only under the macro.

Verification
REQ-032 err_corrected_i[3] high 5 cycles, cnt_sel_i=3 -> cnt_o=5, 5 log entries src=3 type=0 (FIFO_DEPTH=4, no pop: 4 logged, drop_cnt_o=1).
REQ-033 err_detected_i[6] one-cycle pulse -> det_flags_o=8'h40 and fatal_o=1 next cycle, held 100 cycles; clear_i -> both 0.
REQ-034 Same cycle err_corrected_i=8'h0A, err_detected_i[1]=1 -> logged src=1 type=1, drop_cnt_o=1, cnt_o(src 3)=1, cnt_o(src 1)=0.
REQ-035 CNT_W=4, 20 corrected pulses on src 0 -> cnt_o saturates at 15.
REQ-036 Full log, push and evt_ready_i=1 same cycle -> head advances, new entry at tail, drop_cnt_o unchanged; rst asserted mid-stream -> evt_valid_o=0 immediately.
REQ-037 Build without CV32E40P_FT_ERR_LOG_EN, repeat REQ-032 -> cnt_o=5, evt_valid_o=0, drop_cnt_o=0.
